isqrt_seq: RTL

ISQRT_SEQ -- requirements
Module: isqrt_seq

---
 rtl/isqrt_pkg.sv | 12 +
 rtl/isqrt_step.sv | 29 ++
 rtl/isqrt_seq.sv | 108 ++++++++++
 3 files changed

// File: rtl/isqrt_pkg.sv
// Shared constants and state encoding for the sequential integer square-root unit.
package isqrt_pkg;

    localparam int DEFAULT_WIDTH = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/isqrt_step.sv
// One restoring digit-by-digit square-root step: bring down a radicand bit pair,
// try subtracting (root<<2)|1, and shift the resulting root bit in.
module isqrt_step #(
    parameter int HALF = 16
) (
    input  logic [HALF-1:0] rem_in,
    input  logic [HALF-1:0] root_in,
    input  logic [1:0]      pair,
    output logic [HALF:0]   rem_out,
    output logic [HALF-1:0] root_out
);

    // Before any step the partial root holds at most HALF-1 bits and the
    // remainder is <= 2*root, so the operands below never lose significant bits.
    logic [HALF+1:0] shifted;
    logic [HALF+1:0] trial;
    logic            take;

    // NOTE: every output of a combinational block is assigned on every path,
    // otherwise synthesis infers a latch to hold the old value.
    always_comb begin
        shifted  = {rem_in, pair};
        trial    = {root_in, 2'b01};
        take     = (shifted >= trial);
        rem_out  = take ? (HALF+1)'(shifted - trial) : (HALF+1)'(shifted);
        root_out = {root_in[HALF-2:0], take};
    end

endmodule

// File: rtl/isqrt_seq.sv
// Sequential integer square root: floor(sqrt(x)) and remainder, one root bit
// per clock, with valid/ready handshakes on both sides.
module isqrt_seq
    import isqrt_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   in_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH/2-1:0] out_root,
    output logic [WIDTH/2:0]   out_rem,
    output logic               busy
);

    localparam int HALF  = WIDTH / 2;
    localparam int CNT_W = (HALF > 1) ? $clog2(HALF) : 1;
    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(HALF - 1);

    state_t           state;
    logic [WIDTH-1:0] x_q;
    logic [HALF-1:0]  root_q;
    logic [HALF:0]    rem_q;
    logic [CNT_W-1:0] cnt_q;
    logic             in_ready_q;
    logic             busy_q;
    logic             out_valid_q;

    logic [HALF:0]    rem_nxt;
    logic [HALF-1:0]  root_nxt;

    // Remainder bit HALF is only ever set by the final step, so the step
    // datapath consumes the low HALF bits.
    isqrt_step #(.HALF(HALF)) u_step (
        .rem_in   (rem_q[HALF-1:0]),
        .root_in  (root_q),
        .pair     (x_q[WIDTH-1 -: 2]),
        .rem_out  (rem_nxt),
        .root_out (root_nxt)
    );

    // NOTE: state registers use non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            x_q         <= '0;
            root_q      <= '0;
            rem_q       <= '0;
            cnt_q       <= '0;
            in_ready_q  <= 1'b1;
            busy_q      <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        x_q        <= in_data;
                        root_q     <= '0;
                        rem_q      <= '0;
                        cnt_q      <= '0;
                        state      <= BUSY;
                        in_ready_q <= 1'b0;
                        busy_q     <= 1'b1;
                    end
                end
                BUSY: begin
                    x_q    <= x_q << 2;
                    root_q <= root_nxt;
                    rem_q  <= rem_nxt;
                    cnt_q  <= cnt_q + 1'b1;
                    if (cnt_q == LAST_STEP) begin
                        state       <= DONE;
                        busy_q      <= 1'b0;
                        out_valid_q <= 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state       <= IDLE;
                        root_q      <= '0;
                        rem_q       <= '0;
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                    end
                end
                default: begin
                    state       <= IDLE;
                    in_ready_q  <= 1'b1;
                    busy_q      <= 1'b0;
                    out_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign busy      = busy_q;
    assign out_valid = out_valid_q;
    // Working registers are live during BUSY; expose them only once final.
    assign out_root  = out_valid_q ? root_q : '0;
    assign out_rem   = out_valid_q ? rem_q  : '0;

endmodule
